// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, status codes, condition-code type and the
// pipeline-bubble control word used by the execute stage.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'h0,
    ALU_SUB = 4'h1,
    ALU_AND = 4'h2,
    ALU_XOR = 4'h3,
    ALU_OR  = 4'h4,
    ALU_SHL = 4'h5,
    ALU_SAR = 4'h6
  } alu_fun_e;

  typedef enum logic [3:0] {
    C_YES = 4'h0,
    C_LE  = 4'h1,
    C_L   = 4'h2,
    C_E   = 4'h3,
    C_NE  = 4'h4,
    C_GE  = 4'h5,
    C_G   = 4'h6
  } cond_e;

  typedef enum logic [2:0] {
    STAT_AOK = 3'd1,
    STAT_HLT = 3'd2,
    STAT_ADR = 3'd3,
    STAT_INS = 3'd4
  } stat_e;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] NOP   = 4'h1;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

  // Width-independent part of the E->M register; data words clear separately.
  typedef struct packed {
    logic [2:0] stat;
    logic [3:0] icode;
    logic       cnd;
    logic [3:0] dste;
    logic [3:0] dstm;
  } m_ctrl_t;

  localparam m_ctrl_t M_BUBBLE = '{stat: STAT_AOK, icode: NOP, cnd: 1'b0,
                                   dste: RNONE, dstm: RNONE};

  function automatic logic alu_fun_ok(input logic [3:0] fun, input logic ext);
    return (fun <= ALU_XOR) || (ext && (fun <= ALU_SAR));
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode-side inputs, control and E->M outputs of the execute stage.
interface execute_stage_if #(
  parameter int N = 64
);

  logic         e_stall;
  logic         e_bubble;
  logic [2:0]   E_stat;
  logic [3:0]   E_icode;
  logic [3:0]   E_ifun;
  logic [N-1:0] E_valA;
  logic [N-1:0] E_valB;
  logic [N-1:0] E_valC;
  logic [3:0]   E_dstE;
  logic [3:0]   E_dstM;
  logic [2:0]   m_stat;
  logic [2:0]   W_stat;

  logic [N-1:0] e_valE;
  logic [3:0]   e_dstE;
  logic         e_cnd;
  logic [2:0]   cc_out;
  logic [2:0]   M_stat;
  logic [3:0]   M_icode;
  logic         M_cnd;
  logic [N-1:0] M_valE;
  logic [N-1:0] M_valA;
  logic [3:0]   M_dstE;
  logic [3:0]   M_dstM;

  modport master (
    output e_stall, e_bubble, E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC,
           E_dstE, E_dstM, m_stat, W_stat,
    input  e_valE, e_dstE, e_cnd, cc_out, M_stat, M_icode, M_cnd, M_valE,
           M_valA, M_dstE, M_dstM
  );

  modport slave (
    input  e_stall, e_bubble, E_stat, E_icode, E_ifun, E_valA, E_valB, E_valC,
           E_dstE, E_dstM, m_stat, W_stat,
    output e_valE, e_dstE, e_cnd, cc_out, M_stat, M_icode, M_cnd, M_valE,
           M_valA, M_dstE, M_dstM
  );

endinterface

// File: rtl/alu_flags.sv
// N-bit Y86 ALU: computes alu_b <op> alu_a and the {ZF,SF,OF} flags it
// would write; fun_ok reports whether the op exists in this build.
module alu_flags
  import y86_pkg::*;
#(
  parameter int N       = 64,
  parameter int EXT_OPS = 0
) (
  input  logic signed [N-1:0] alu_a,
  input  logic signed [N-1:0] alu_b,
  input  logic        [3:0]   alu_fun,
  output logic signed [N-1:0] result,
  output cc_t                 flags,
  output logic                fun_ok
);

  localparam int  SH_W = $clog2(N);
  localparam logic EXT = (EXT_OPS != 0);

  logic [SH_W-1:0] shamt;
  logic            ovf;

  assign shamt = alu_a[SH_W-1:0];

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    fun_ok = alu_fun_ok(alu_fun, EXT);
    case (alu_fun)
      ALU_ADD: begin
        result = alu_b + alu_a;
        ovf    = (alu_a[N-1] == alu_b[N-1]) && (result[N-1] != alu_b[N-1]);
      end
      ALU_SUB: begin
        result = alu_b - alu_a;
        ovf    = (alu_a[N-1] != alu_b[N-1]) && (result[N-1] != alu_b[N-1]);
      end
      ALU_AND: result = alu_b & alu_a;
      ALU_XOR: result = alu_b ^ alu_a;
      ALU_OR:  if (EXT) result = alu_b | alu_a;
      ALU_SHL: if (EXT) result = alu_b << shamt;
      // alu_b is signed, so >>> replicates the sign bit.
      ALU_SAR: if (EXT) result = alu_b >>> shamt;
      default: result = '0;
    endcase
    flags.zf = (result == '0);
    flags.sf = result[N-1];
    flags.of = ovf;
  end

endmodule

// File: rtl/execute_stage.sv
// Pipelined Y86-64 execute stage: operand select, ALU, gated condition
// codes, jump/cmov resolution and the E->M pipeline register.
module execute_stage
  import y86_pkg::*;
#(
  parameter int N       = 64,
  parameter int EXT_OPS = 0
) (
  input  logic          clk,
  input  logic          reset,
  execute_stage_if.slave bus
);

  localparam logic signed [N-1:0] WORD_BYTES = N'(N / 8);

  logic signed [N-1:0] alu_a;
  logic signed [N-1:0] alu_b;
  logic        [3:0]   alu_fun;
  logic                use_alu;
  logic signed [N-1:0] alu_result;
  cc_t                 alu_cc;
  logic                fun_ok;

  logic [N-1:0] vale;
  logic         cnd;
  logic [3:0]   dste;
  logic         cc_wr;

  cc_t          cc_p1;
  m_ctrl_t      m_ctrl_p1;
  logic [N-1:0] m_vale_p1;
  logic [N-1:0] m_vala_p1;

  // Operand routing: everything not computed by an OPq is an add.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_fun = ALU_ADD;
    use_alu = 1'b1;
    case (bus.E_icode)
      I_RRMOVQ: alu_a = bus.E_valA;
      I_IRMOVQ: alu_a = bus.E_valC;
      I_RMMOVQ, I_MRMOVQ: begin
        alu_a = bus.E_valC;
        alu_b = bus.E_valB;
      end
      I_CALL, I_PUSHQ: begin
        alu_a = -WORD_BYTES;
        alu_b = bus.E_valB;
      end
      I_RET, I_POPQ: begin
        alu_a = WORD_BYTES;
        alu_b = bus.E_valB;
      end
      I_OPQ: begin
        alu_a   = bus.E_valA;
        alu_b   = bus.E_valB;
        alu_fun = bus.E_ifun;
      end
      default: use_alu = 1'b0;
    endcase
  end

  alu_flags #(
    .N       (N),
    .EXT_OPS (EXT_OPS)
  ) u_alu (
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_fun (alu_fun),
    .result  (alu_result),
    .flags   (alu_cc),
    .fun_ok  (fun_ok)
  );

  assign vale = use_alu ? alu_result : '0;

  // Conditions read the registered CC only, never this cycle's ALU flags.
  always_comb begin
    case (bus.E_ifun)
      C_YES:   cnd = 1'b1;
      C_LE:    cnd = (cc_p1.sf ^ cc_p1.of) | cc_p1.zf;
      C_L:     cnd = cc_p1.sf ^ cc_p1.of;
      C_E:     cnd = cc_p1.zf;
      C_NE:    cnd = ~cc_p1.zf;
      C_GE:    cnd = ~(cc_p1.sf ^ cc_p1.of);
      C_G:     cnd = ~(cc_p1.sf ^ cc_p1.of) & ~cc_p1.zf;
      default: cnd = 1'b0;
    endcase
  end

  assign dste  = ((bus.E_icode == I_RRMOVQ) && !cnd) ? RNONE : bus.E_dstE;

  assign cc_wr = (bus.E_icode == I_OPQ) && fun_ok &&
                 (bus.m_stat == STAT_AOK) && (bus.W_stat == STAT_AOK) &&
                 !bus.e_stall;

  // Stage boundary: condition-code register
  always_ff @(posedge clk) begin
    if (reset) begin
      cc_p1 <= CC_RESET;
    end else if (cc_wr) begin
      cc_p1 <= alu_cc;
    end
  end

  // Stage boundary: E->M pipeline register
  always_ff @(posedge clk) begin
    if (reset || bus.e_bubble) begin
      m_ctrl_p1 <= M_BUBBLE;
      m_vale_p1 <= '0;
      m_vala_p1 <= '0;
    end else if (!bus.e_stall) begin
      m_ctrl_p1.stat  <= bus.E_stat;
      m_ctrl_p1.icode <= bus.E_icode;
      m_ctrl_p1.cnd   <= cnd;
      m_ctrl_p1.dste  <= dste;
      m_ctrl_p1.dstm  <= bus.E_dstM;
      m_vale_p1       <= vale;
      m_vala_p1       <= bus.E_valA;
    end
  end

  assign bus.e_valE  = vale;
  assign bus.e_dstE  = dste;
  assign bus.e_cnd   = cnd;
  assign bus.cc_out  = cc_p1;
  assign bus.M_stat  = m_ctrl_p1.stat;
  assign bus.M_icode = m_ctrl_p1.icode;
  assign bus.M_cnd   = m_ctrl_p1.cnd;
  assign bus.M_valE  = m_vale_p1;
  assign bus.M_valA  = m_vala_p1;
  assign bus.M_dstE  = m_ctrl_p1.dste;
  assign bus.M_dstM  = m_ctrl_p1.dstm;

endmodule

// File: doc/execute_stage.md
# execute_stage

Pipelined Y86-64 execute stage: selects ALU operands per instruction, computes valE and condition flags, holds the condition-code register with exception-gated update, resolves jump/cmov conditions, and registers results into the E→M pipeline register with stall/bubble control. It sits between the decode pipeline register (E) and the memory stage (M). It generalises the single-cycle execute unit with a width parameter, optional extended ALU ops, and a registered, controllable pipeline boundary.

## Interface
- N, 64: datapath width (multiple of 8, ≥16)
- EXT_OPS, 0: 1 enables OPq ifun 4 (OR), 5 (SHL), 6 (SAR)
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- e_stall  in  1  hold M register and CC
- e_bubble  in  1  load bubble into M register
- E_stat  in  3  stage status (AOK=1, HLT=2, ADR=3, INS=4)
- E_icode, E_ifun  in  4 each  instruction code/function
- E_valA, E_valB, E_valC  in  N each  operands
- E_dstE, E_dstM  in  4 each  destination registers (RNONE=4'hF)
- m_stat, W_stat  in  3 each  downstream stage status
- e_valE  out  N  combinational ALU result (forwarding)
- e_dstE  out  4  combinational dstE after cmov resolution
- e_cnd  out  1  combinational condition result
- cc_out  out  3  registered {ZF,SF,OF}
- M_stat, M_icode, M_cnd, M_valE, M_valA, M_dstE, M_dstM  out  registered E→M fields

## Operation
- valE by icode: 3 irmovq → valC; 4/5 rmmovq/mrmovq → valB+valC; 2 cmov → valA; 8/10 call/pushq → valB−N/8; 9/11 ret/popq → valB+N/8; 6 OPq → valB op valA; others → 0. Arithmetic modulo 2^N.
- OPq ifun: 0 add, 1 sub (valB−valA), 2 and, 3 xor; with EXT_OPS=1: 4 or, 5 SHL by valA[log2(N)-1:0], 6 SAR likewise. Unsupported ifun → valE=0, CC not written.
- Flags: ZF = (valE==0); SF = valE[N-1]; OF add = sign(valA)==sign(valB) && sign(valE)!=sign(valB); OF sub = sign(valA)!=sign(valB) && sign(valE)!=sign(valB); logical/shift OF=0.
- CC write when E_icode==6, supported ifun, m_stat==AOK, W_stat==AOK, !e_stall, !reset.
- Condition from registered CC (never same-cycle flags): ifun 0 1; 1 (SF^OF)|ZF; 2 SF^OF; 3 ZF; 4 !ZF; 5 !(SF^OF); 6 !(SF^OF)&!ZF; ≥7 0.
- e_dstE = RNONE when E_icode==2 and !e_cnd, else E_dstE.
- M register loads {E_stat, E_icode, e_cnd, e_valE, E_valA, e_dstE, E_dstM}.
- Bubble value: stat AOK, icode NOP (1), ifun/cnd 0, valE/valA 0, dstE/dstM RNONE.

## Timing
- Priority: reset > e_bubble > e_stall > load.
- Reset: M register = bubble value; cc_out = 3'b100.
- e_valE/e_dstE/e_cnd are combinational in the same cycle as E inputs; M_* valid one cycle later.
- CC written at the edge ending the OPq's E cycle; a cmov/jXX in E the following cycle sees it.
- e_stall: M_* and CC hold exactly; combinational outputs still track inputs.
- e_bubble with e_stall: bubble wins; CC still held (stall gate).
- Exception in m_stat or W_stat on the OPq's E cycle: CC unchanged, M register still loads.
- Reset asserted mid-stream: next edge clears M and CC regardless of other inputs.

## Structure
- Package y86_pkg: icode/ifun enums, stat codes, RNONE, NOP, cc_t struct {zf,sf,of}, bubble constant.
- Sub-module alu_flags (parametrised N, EXT_OPS): operand op → result and {ZF,SF,OF}. CC register, condition logic, and M register stay in execute_stage.

## Test plan
- After reset: cc_out=100, M_icode=1, M_dstE=F; jXX ifun 3 → e_cnd=1.
- OPq sub valB=5, valA=5 → e_valE=0, next cycle cc_out=100; valB=0x7FFF..F add valA=1 → valE=0x8000..0, cc_out=011.
- OPq with m_stat=ADR → CC unchanged; cmov ifun 2 with SF^OF=0, E_dstE=3 → e_dstE=F, M_dstE=F next cycle.
- pushq valB=0x100 → e_valE=0xF8; popq → 0x108; N=32 instance → 0xFC / 0x104.
- e_stall 2 cycles during OPq: M_* and cc_out frozen; e_bubble+e_stall → M_icode=1.
- EXT_OPS=1 SAR valB=0x80..0, valA=4 → 0xF80..0, SF=1, OF=0; EXT_OPS=0 same op → valE=0, CC unchanged.
